// File: rtl/dram_load_ctl.sv
`default_nettype none
// ============================================================================
// Module   : dram_load_ctl
// Function : diagnostic load/readback controller for the instruction dispatch
//            RAM; lookups always own the RAM port, diagnostic accesses wait.
// Revision : 1.0
// ============================================================================
module dram_load_ctl #(
    parameter int AUTO_PAR = 1,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        diag_strobe,
    input  logic [2:0]  diag_func,
    input  logic [5:0]  diag_data,
    input  logic        lookup_req,
    input  logic [8:0]  lookup_adr,
    output logic [8:0]  ram_adr,
    output logic        ram_we,
    output logic [14:0] ram_din,
    input  logic [14:0] ram_dout,
    output logic [14:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        par_err,
    output logic [8:0]  wr_adr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_PEND = 3'd1,
        S_WR      = 3'd2,
        S_RD_PEND = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_CAP  = 3'd5
    } state_t;

    localparam logic c_wait_last = (RD_LAT == 2);

    state_t      r_state;
    logic [14:0] r_stage;   // [14:9]=A,B  [8]=P  [7:4]=J1:4  [3:0]=J7:10
    logic        r_cnt;
    logic        w_par;

    assign busy    = (r_state != S_IDLE);
    assign ram_we  = (r_state == S_WR) && !lookup_req;
    assign ram_adr = lookup_req ? lookup_adr : wr_adr;
    assign w_par   = ~^{r_stage[14:9], r_stage[7:0]};
    assign ram_din = {r_stage[14:9], (AUTO_PAR != 0) ? w_par : r_stage[8], r_stage[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_stage  <= '0;
            r_cnt    <= 1'b0;
            wr_adr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (diag_strobe) begin
                        rd_valid <= 1'b0;
                        case (diag_func)
                            3'b000: wr_adr        <= {diag_data, 3'b000};
                            3'b001: wr_adr[2:0]   <= diag_data[2:0];
                            3'b010: r_stage[14:9] <= diag_data;
                            3'b011: r_stage[8:4]  <= diag_data[4:0];
                            3'b100: begin
                                r_stage[3:0] <= diag_data[3:0];
                                r_state      <= S_WR_PEND;
                            end
                            3'b101: r_state <= S_RD_PEND;
                            3'b110: par_err <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_WR_PEND: begin
                    if (!lookup_req) r_state <= S_WR;
                end
                S_WR: begin
                    // A lookup arriving in this cycle masks ram_we, so the write is retried.
                    if (!lookup_req) begin
                        wr_adr  <= wr_adr + 9'd1;
                        r_state <= S_IDLE;
                    end
                end
                S_RD_PEND: begin
                    if (!lookup_req) begin
                        r_cnt   <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == c_wait_last) r_state <= S_RD_CAP;
                    else                      r_cnt   <= 1'b1;
                end
                S_RD_CAP: begin
                    rd_data  <= ram_dout;
                    rd_valid <= 1'b1;
                    par_err  <= par_err | ~^ram_dout;
                    wr_adr   <= wr_adr + 9'd1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
